ac_register: RTL and testbench

AC_REGISTER -- requirements
Module: ac_register

---
 rtl/ac_register_pkg.sv | 7 +
 rtl/ac_register_if.sv | 25 ++
 rtl/ac_register.sv | 31 +++
 tb/tb_ac_register.sv | 127 ++++++++++++
 4 files changed

// File: rtl/ac_register_pkg.sv
// Shared processor constants used by the accumulator and its bus interface.
package ac_register_pkg;

  // Native data width of the processor datapath.
  localparam int PROC_WIDTH = 16;

endpackage

// File: rtl/ac_register_if.sv
// Control/data bundle between the processor datapath and the accumulator.
interface ac_register_if
  import ac_register_pkg::*;
#(
  parameter int WIDTH = PROC_WIDTH
);
  logic             write_en;
  logic             alu_to_ac;
  logic             inc_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] data_out;
  logic             zero;

  // The datapath controller drives operands and enables and observes AC.
  modport master (
    output write_en, alu_to_ac, inc_en, data_in, alu_out,
    input  data_out, zero
  );

  modport slave (
    input  write_en, alu_to_ac, inc_en, data_in, alu_out,
    output data_out, zero
  );
endinterface

// File: rtl/ac_register.sv
// Accumulator register: prioritised load / ALU write-back / increment / hold,
// with a zero flag decoded straight from the register.
module ac_register
  import ac_register_pkg::*;
#(
  parameter int WIDTH = PROC_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  ac_register_if.slave  bus
);

  logic [WIDTH-1:0] ac;

  // Priority: reset, bus load, ALU write-back, increment (wraps), hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ac <= '0;
    end else if (bus.write_en) begin
      ac <= bus.data_in;
    end else if (bus.alu_to_ac) begin
      ac <= bus.alu_out;
    end else if (bus.inc_en) begin
      ac <= ac + WIDTH'(1);
    end
  end

  assign bus.data_out = ac;
  assign bus.zero     = (ac == '0);

endmodule

// File: tb/tb_ac_register.sv
// Directed, table-driven bench for the accumulator register.
module tb_ac_register;
  import ac_register_pkg::*;

  localparam int W = PROC_WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  ac_register_if #(.WIDTH(W)) bus ();

  ac_register #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         we;
    logic         alu;
    logic         inc;
    logic [W-1:0] din;
    logic [W-1:0] aout;
    logic [W-1:0] exp_out;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic we, input logic alu,
                     input logic inc, input logic [W-1:0] din, input logic [W-1:0] aout,
                     input logic [W-1:0] eo, input logic ez);
    vec_t v;
    v.name = n; v.rst = r; v.we = we; v.alu = alu; v.inc = inc;
    v.din = din; v.aout = aout; v.exp_out = eo; v.exp_zero = ez;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [W-1:0] eo, input logic ez);
    tests++;
    if (bus.data_out !== eo || bus.zero !== ez) begin
      fails++;
      $display("FAIL %s: data_out=%h zero=%b, expected data_out=%h zero=%b",
               n, bus.data_out, bus.zero, eo, ez);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic alu, input logic inc,
                       input logic [W-1:0] din, input logic [W-1:0] aout);
    rst = r; bus.write_en = we; bus.alu_to_ac = alu; bus.inc_en = inc;
    bus.data_in = din; bus.alu_out = aout;
  endtask

  task automatic step_check(input string n, input logic [W-1:0] eo, input logic ez);
    @(posedge clk);
    #1;
    check(n, eo, ez);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    add("reset",       1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1);
    add("inc1",        0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0001, 0);
    add("inc2",        0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0002, 0);
    add("inc3",        0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0003, 0);
    add("inc4",        0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0004, 0);
    add("inc5",        0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0005, 0);
    add("load75",      0, 1, 0, 0, 16'd75,   16'h0000, 16'd75,   0);
    add("hold1",       0, 0, 0, 0, 16'h1111, 16'h2222, 16'd75,   0);
    add("hold2",       0, 0, 0, 0, 16'h3333, 16'h4444, 16'd75,   0);
    add("hold3",       0, 0, 0, 0, 16'h0000, 16'h0000, 16'd75,   0);
    add("alu56",       0, 0, 1, 0, 16'h9999, 16'd56,   16'd56,   0);
    add("prio_we",     0, 1, 1, 1, 16'h1234, 16'h00FF, 16'h1234, 0);
    add("prio_alu",    0, 0, 1, 1, 16'h1234, 16'h00FF, 16'h00FF, 0);
    add("load_ffff",   0, 1, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0);
    add("wrap",        0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 1);
    add("load_ab",     0, 1, 0, 0, 16'h00AB, 16'h0000, 16'h00AB, 0);
    add("rst_over_we", 1, 1, 1, 1, 16'h5555, 16'h7777, 16'h0000, 1);
    add("inc_a",       0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0001, 0);
    add("inc_b",       0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0002, 0);
    add("rst_mid_inc", 1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 1);
    add("inc_resume",  0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0001, 0);
    add("inc_ign_ops", 0, 0, 0, 1, 16'hAAAA, 16'h5555, 16'h0002, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].alu, vecs[i].inc, vecs[i].din, vecs[i].aout);
      step_check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_zero);
    end

    // Asynchronous-looking reset pulse between edges must not disturb AC.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h00AB, 16'h0000);
    step_check("load_ab2", 16'h00AB, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2 rst = 1'b1;
    #2 check("rst_glitch_during", 16'h00AB, 1'b0);
    rst = 1'b0;
    step_check("rst_glitch_after", 16'h00AB, 1'b0);

    // Operand changes between edges must not reach data_out combinationally.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0);
    #1 check("no_comb_path", 16'h00AB, 1'b0);
    bus.data_in = 16'h0000;
    #1 check("no_comb_path_zero", 16'h00AB, 1'b0);
    step_check("load_zero", 16'h0000, 1'b1);

    // Long run of increments, then an extended idle period.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    repeat (40) @(posedge clk);
    #1 check("inc_run40", 16'd40, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    repeat (20) @(posedge clk);
    #1 check("hold_long", 16'd40, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
